uart_fifo_param: RTL

Parametrised successor to the UART byte FIFO: a single-clock circular FIFO with configurable data width and depth, selectable overflow policy, programmable almost-full/almost-empty flags, a synchronous flush, and a saturating overflow counter. It sits between the wishbone UART register interface and the UART TX/RX engines, one instance per direction. All 2^ADDR_WIDTH entries are usable.

---
 rtl/uart_fifo_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_fifo_param.sv
// Parametrised single-clock circular byte FIFO between the UART register interface and a
// TX/RX engine. It has a selectable overflow policy, level flags, a flush and an overflow counter.
module uart_fifo_param #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDR_WIDTH         = 4,
  parameter bit          OVERWRITE          = 1'b1,
  parameter int unsigned ALMOST_FULL_LEVEL  = 12,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  write_strobe,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_strobe,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [31:0]           read_count,
  output logic [31:0]           write_available,
  output logic [31:0]           size,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           overflow_count
);

  localparam int unsigned           Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [ADDR_WIDTH-1:0] in_ptr_q, in_ptr_d;
  logic [ADDR_WIDTH-1:0] out_ptr_q, out_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           ovf_count_q, ovf_count_d;
  logic                  mem_we;
  logic                  is_full, is_empty;

  assign is_full  = (count_q == DepthCnt);
  assign is_empty = (count_q == '0);

  always_comb begin
    in_ptr_d    = in_ptr_q;
    out_ptr_d   = out_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    ovf_count_d = ovf_count_q;
    mem_we      = 1'b0;

    if (clear) begin
      in_ptr_d    = '0;
      out_ptr_d   = '0;
      count_d     = '0;
      ovf_count_d = '0;
    end else begin
      case ({write_strobe, read_strobe})
        2'b10: begin
          if (!is_full) begin
            mem_we   = 1'b1;
            in_ptr_d = in_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
            // Overwrite policy drops the oldest entry by advancing both pointers.
            if (OVERWRITE) begin
              mem_we    = 1'b1;
              in_ptr_d  = in_ptr_q + 1'b1;
              out_ptr_d = out_ptr_q + 1'b1;
            end
          end
        end
        2'b01: begin
          if (!is_empty) begin
            out_ptr_d = out_ptr_q + 1'b1;
            count_d   = count_q - 1'b1;
          end else begin
            underflow_d = 1'b1;
          end
        end
        2'b11: begin
          mem_we   = 1'b1;
          in_ptr_d = in_ptr_q + 1'b1;
          if (!is_empty) begin
            out_ptr_d = out_ptr_q + 1'b1;
          end else begin
            // No fall-through: the write lands, the read is rejected.
            count_d     = count_q + 1'b1;
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase

      if (overflow_d && (ovf_count_q != 16'hFFFF)) begin
        ovf_count_d = ovf_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ptr_q    <= '0;
      out_ptr_q   <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      in_ptr_q    <= in_ptr_d;
      out_ptr_q   <= out_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[in_ptr_q] <= write_data;
    end
  end

  assign read_data       = mem_q[out_ptr_q];
  assign read_count      = 32'(count_q);
  assign write_available = Depth - read_count;
  assign size            = Depth;
  assign full            = is_full;
  assign empty           = is_empty;
  assign almost_full     = (read_count >= ALMOST_FULL_LEVEL);
  assign almost_empty    = (read_count <= ALMOST_EMPTY_LEVEL);
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;
  assign overflow_count  = ovf_count_q;

endmodule
